// File: rtl/aes_pkg.sv
// Shared AES definitions: controller states, round count, Rcon table and
// GF(2^8) helpers used by the byte-substitution and column-mix logic.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } aes_state_e;

  // Indexed directly by the 4-bit round counter; unused slots read zero.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (a^254, zero maps to zero)
  // followed by the FIPS-197 affine transform.
  function automatic logic [7:0] sbox_fn(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: derives the next round key from the current
// one using RotWord/SubWord/Rcon on the last word and a chained word XOR.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [0:127] rk,
  input  logic [3:0]   rnd,
  output logic [0:127] next_rk
);

  logic [7:0]  sub [4];
  logic [0:31] tmp, w0, w1, w2, w3;

  // RotWord folded into the S-box input selection
  for (genvar i = 0; i < 4; i++) begin : g_sub
    sbox u_sbox (.a(rk[96 + 8*((i+1)%4) +: 8]), .y(sub[i]));
  end

  assign tmp = {sub[0] ^ RCON[rnd], sub[1], sub[2], sub[3]};
  assign w0  = rk[0  +: 32] ^ tmp;
  assign w1  = rk[32 +: 32] ^ w0;
  assign w2  = rk[64 +: 32] ^ w1;
  assign w3  = rk[96 +: 32] ^ w2;
  assign next_rk = {w0, w1, w2, w3};

endmodule

// File: rtl/mix_col.sv
// AES MixColumns applied to all four columns of the state.
module mix_col
  import aes_pkg::*;
(
  input  logic [0:127] din,
  output logic [0:127] dout
);

  // fixed {02,03,01,01} circulant multiply per column
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    dout = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = din[32*c      +: 8];
      a1 = din[32*c + 8  +: 8];
      a2 = din[32*c + 16 +: 8];
      a3 = din[32*c + 24 +: 8];
      dout[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      dout[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      dout[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      dout[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

endmodule

// File: rtl/sbox.sv
// Single AES forward S-box lookup.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = sbox_fn(a);

endmodule

// File: rtl/shift_rows.sv
// AES ShiftRows on a column-major 128-bit state (byte i at row i%4, col i/4).
module shift_rows (
  input  logic [0:127] din,
  output logic [0:127] dout
);

  // row r rotates left by r columns
  always_comb begin
    dout = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        dout[8*(4*c+r) +: 8] = din[8*(4*((c+r)%4)+r) +: 8];
      end
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, ciphertext held with a
// valid/ready handshake until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for a job, in_ready high
// ROUND | full rounds 1..NR-1 (SubBytes, ShiftRows, MixColumns, AddRoundKey)
// FINAL | last round, no MixColumns
// DONE  | ciphertext presented until out_ready
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  input  logic [0:127] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
);

  aes_state_e   state, state_nxt;
  logic [0:127] state_reg, rk_reg, next_rk;
  logic [0:127] sb_out, sr_out, mc_out;
  logic [3:0]   rnd;
  logic         accept;

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    sbox u_sbox (.a(state_reg[8*i +: 8]), .y(sb_out[8*i +: 8]));
  end

  shift_rows   u_shift_rows (.din(sb_out), .dout(sr_out));
  mix_col      u_mix_col    (.din(sr_out), .dout(mc_out));
  aes_key_step u_key_step   (.rk(rk_reg), .rnd(rnd), .next_rk(next_rk));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        accept   = in_valid;
        if (in_valid) state_nxt = ROUND;
      end
      ROUND: if (rnd == 4'(NR-1)) state_nxt = FINAL;
      FINAL: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // round datapath; registers only move on accept or while computing rounds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= '0;
      rk_reg    <= '0;
      rnd       <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state_reg <= in_data ^ in_key;
          rk_reg    <= in_key;
          rnd       <= 4'd1;
        end
        ROUND: begin
          state_reg <= mc_out ^ next_rk;
          rk_reg    <= next_rk;
          rnd       <= rnd + 4'd1;
        end
        FINAL: begin
          state_reg <= sr_out ^ next_rk;
          rk_reg    <= next_rk;
          rnd       <= '0;
        end
        default: ;
      endcase
    end
  end

  assign out_data = out_valid ? state_reg : '0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl using FIPS-197 vectors.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [0:127] in_data = '0;
  logic [0:127] in_key = '0;
  logic         in_ready, out_valid, busy;
  logic [0:127] out_data;

  int checks = 0;
  int errors = 0;

  localparam logic [0:127] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 40) begin
      step();
      edges++;
    end
  endtask

  task automatic start_job(input logic [0:127] k, input logic [0:127] p);
    in_key   = k;
    in_data  = p;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: out_valid=%b busy=%b, want 0 0", out_valid, busy);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_out_data: got %h, want 0", out_data);
    end
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
  endtask

  task automatic test_app_b_backpressure();
    int e;
    start_job(KEY_B, PT_B);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL first_accept: busy=%b in_ready=%b, want 1 0", busy, in_ready);
    end
    wait_valid(e);
    checks++;
    if (e != 10) begin
      errors++;
      $display("FAIL latency_b: got %0d edges, want 10", e);
    end
    checks++;
    if (out_data !== CT_B) begin
      errors++;
      $display("FAIL ct_b: got %h, want %h", out_data, CT_B);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== CT_B) begin
        errors++;
        $display("FAIL hold_%0d: out_valid=%b in_ready=%b data=%h, want 1 0 %h",
                 i, out_valid, in_ready, out_data, CT_B);
      end
    end
    retire();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL retire_b: out_valid=%b in_ready=%b busy=%b data=%h, want 0 1 0 0",
               out_valid, in_ready, busy, out_data);
    end
  endtask

  task automatic test_busy_input();
    int e;
    start_job(KEY_C, PT_C);
    repeat (2) step();
    for (int i = 0; i < 6; i++) begin
      in_valid  = ~in_valid;
      in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_key    = {$urandom(), $urandom(), $urandom(), $urandom()};
      out_ready = i[0];
      step();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL busy_rnd_%0d: in_ready=%b out_valid=%b, want 0 0", i, in_ready, out_valid);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    wait_valid(e);
    checks++;
    if (e + 8 != 10) begin
      errors++;
      $display("FAIL latency_c: got %0d edges, want 10", e + 8);
    end
    checks++;
    if (out_data !== CT_C) begin
      errors++;
      $display("FAIL ct_c_busy: got %h, want %h", out_data, CT_C);
    end
    retire();
  endtask

  task automatic test_reset_mid_job();
    int e;
    start_job(KEY_B, PT_B);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b busy=%b in_ready=%b data=%h, want 0 0 1 0",
               out_valid, busy, in_ready, out_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_job(KEY_B, PT_B);
    wait_valid(e);
    checks++;
    if (e != 10 || out_data !== CT_B) begin
      errors++;
      $display("FAIL after_reset_b: edges=%0d data=%h, want 10 %h", e, out_data, CT_B);
    end
    retire();
  endtask

  task automatic test_back_to_back();
    int           acc [2];
    logic [0:127] outs [2];
    int           nacc = 0;
    int           nout = 0;
    logic         accepted;
    in_key    = KEY_B;
    in_data   = PT_B;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && nout < 2; c++) begin
      accepted = 1'b0;
      if (in_valid && in_ready && nacc < 2) begin
        acc[nacc] = c;
        nacc++;
        accepted = 1'b1;
      end
      if (out_valid && nout < 2) begin
        outs[nout] = out_data;
        nout++;
      end
      step();
      if (accepted) begin
        if (nacc == 1) begin
          in_key  = KEY_C;
          in_data = PT_C;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (nacc != 2 || nout != 2) begin
      errors++;
      $display("FAIL b2b_counts: accepts=%0d outputs=%0d, want 2 2", nacc, nout);
    end else begin
      checks++;
      if (acc[1] - acc[0] != 12) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d cycles, want 12", acc[1] - acc[0]);
      end
      checks++;
      if (outs[0] !== CT_B) begin
        errors++;
        $display("FAIL b2b_ct_b: got %h, want %h", outs[0], CT_B);
      end
      checks++;
      if (outs[1] !== CT_C) begin
        errors++;
        $display("FAIL b2b_ct_c: got %h, want %h", outs[1], CT_C);
      end
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b out_valid=%b, want 0 0", busy, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_app_b_backpressure();
    test_busy_input();
    test_reset_mid_job();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
